// File: rtl/uart_pkg.sv
// Shared UART definitions: parser states, SOF marker, byte-time math.
// UART_PARSER_TIMEOUT_EN enables the parser inter-byte timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_e;

  localparam logic [7:0] SOF = 8'hA5;
  localparam int BITS_PER_BYTE = 10;

  function automatic int byte_cycles(
    input int clk_hz,
    input int baud,
    input int nbytes
  );
    longint c;
    c = longint'(nbytes) * BITS_PER_BYTE * clk_hz;
    return int'(c / baud);
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream handshake bundle used on both sides of the parser.
// Optional timeout feature: UART_PARSER_TIMEOUT_EN.
interface uart_frame_parser_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/uart_byte_timer.sv
// Idle-cycle counter: pulses expire after LIMIT cycles without clr.
// Used by the parser only when UART_PARSER_TIMEOUT_EN is defined.
module uart_byte_timer #(
  parameter int LIMIT = 400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (clr || !run) begin
        cnt <= '0;
      end else if (cnt == W'(LIMIT - 1)) begin
        cnt    <= '0;
        expire <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// SOF/LEN/payload/CSUM frame parser with a one-byte hold stage.
// Build option UART_PARSER_TIMEOUT_EN adds an inter-byte timeout.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic clk,
  input  logic rst_n,
  uart_frame_parser_if.slave  s_axis,
  uart_frame_parser_if.master m_axis,
  output logic frame_ok,
  output logic frame_err
);

  localparam int TMO_CYC =
    byte_cycles(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);

  state_e     state;
  logic [7:0] cnt;
  logic [7:0] sum;
  logic [7:0] hold;
  logic       hold_v;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_user;

  logic       slot_free;
  logic       rdy;
  logic       acc;
  logic [7:0] nsum;
  logic       good;
  logic       unused_ok;

  assign slot_free = !m_valid || m_axis.tready;
  assign acc       = s_axis.tvalid && s_axis.tready;
  assign nsum      = sum + s_axis.tdata;
  assign good      = (nsum == 8'h00);
  assign unused_ok =
    ^{s_axis.tlast, s_axis.tuser, TMO_CYC[0]};

`ifdef UART_PARSER_TIMEOUT_EN
  logic flush;
  logic tmo;

  uart_byte_timer #(
    .LIMIT (TMO_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state != ST_IDLE),
    .clr    (acc),
    .expire (tmo)
  );
`endif

  always_comb begin
    rdy = 1'b1;
    unique case (state)
      ST_PAYLOAD, ST_CSUM: rdy = slot_free;
      default:             rdy = 1'b1;
    endcase
`ifdef UART_PARSER_TIMEOUT_EN
    // an aborted frame's byte must leave before new payload
    if (flush && (state == ST_PAYLOAD || state == ST_CSUM))
      rdy = 1'b0;
`endif
  end

  assign s_axis.tready = rst_n && rdy;

  assign m_axis.tdata  = m_data;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign m_axis.tuser  = m_user;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sum       <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_user    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARSER_TIMEOUT_EN
      flush     <= 1'b0;
`endif
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (m_valid && m_axis.tready)
        m_valid <= 1'b0;
      if (acc) begin
        unique case (state)
          ST_IDLE: begin
            if (s_axis.tdata == SOF) begin
              state <= ST_LEN;
              sum   <= '0;
            end
          end
          ST_LEN: begin
            cnt   <= s_axis.tdata;
            sum   <= nsum;
            state <= (s_axis.tdata != 8'h00) ?
                     ST_PAYLOAD : ST_CSUM;
          end
          ST_PAYLOAD: begin
            sum    <= nsum;
            cnt    <= cnt - 8'd1;
            hold   <= s_axis.tdata;
            hold_v <= 1'b1;
            if (hold_v) begin
              m_data  <= hold;
              m_last  <= 1'b0;
              m_user  <= 1'b0;
              m_valid <= 1'b1;
            end
            if (cnt == 8'd1)
              state <= ST_CSUM;
          end
          ST_CSUM: begin
            if (hold_v) begin
              m_data  <= hold;
              m_last  <= 1'b1;
              m_user  <= !good;
              m_valid <= 1'b1;
            end
            hold_v    <= 1'b0;
            frame_ok  <= good;
            frame_err <= !good;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
`ifdef UART_PARSER_TIMEOUT_EN
      else if (tmo) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        flush     <= hold_v;
      end else if (flush && slot_free) begin
        m_data  <= hold;
        m_last  <= 1'b1;
        m_user  <= 1'b1;
        m_valid <= 1'b1;
        hold_v  <= 1'b0;
        flush   <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized bench for uart_frame_parser against a frame-level model.
// Define UART_PARSER_TIMEOUT_EN to also exercise the timeout path.
module tb_uart_frame_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_ok;
  logic frame_err;

  uart_frame_parser_if s_if();
  uart_frame_parser_if m_if();

  always #5 clk = ~clk;

  uart_frame_parser #(
    .CLK_FREQ      (1_000_000),
    .BAUD_RATE     (100_000),
    .TIMEOUT_BYTES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  typedef logic [9:0] beat_t;

  int    n_chk = 0;
  int    n_err = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    n_ok, n_bad, e_ok, e_bad;
  int    low_cnt = 0;
  bit    rnd_rdy = 1'b0;
  int    gap_max = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  bit    saw_s_stall = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (low_cnt > 0) begin
        m_if.tready = 1'b0;
        low_cnt--;
      end else begin
        m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      b = {m_if.tlast, m_if.tuser, m_if.tdata};
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("hold_stable", {m_if.tvalid, b}, {1'b1, prev_beat});
        if (m_if.tvalid && m_if.tready) got_q.push_back(b);
        if (frame_ok) n_ok++;
        if (frame_err) n_bad++;
        if (!s_if.tready) saw_s_stall = 1'b1;
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_beat  = b;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    @(negedge clk);
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (s_if.tready) begin
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("s_ready_wait", 0, 1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  // Frame-level reference: scan for SOF, take LEN bytes, sum mod 256.
  task automatic model(input logic [7:0] q[$]);
    int i, len, s;
    bit good, lst;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= q.size()) break;
      len = int'(q[i+1]);
      if (i + 2 + len >= q.size()) break;
      s = len;
      for (int k = 0; k <= len; k++) s += int'(q[i+2+k]);
      good = (s % 256) == 0;
      for (int k = 0; k < len; k++) begin
        lst = (k == len - 1);
        exp_q.push_back({lst, lst && !good, q[i+2+k]});
      end
      if (good) e_ok++;
      else e_bad++;
      i += 3 + len;
    end
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    n_ok = 0; n_bad = 0; e_ok = 0; e_bad = 0;
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 3000 && quiet < 8; i++) begin
      @(negedge clk);
      if (m_if.tvalid || s_if.tvalid || low_cnt > 0) quiet = 0;
      else quiet++;
    end
    if (quiet < 8) check("drain_wait", 0, 1);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_nbeats"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_ok"}, n_ok, e_ok);
    check({tag, "_err"}, n_bad, e_bad);
    clear_sb();
  endtask

  task automatic run(input string tag, input logic [7:0] q[$]);
    clear_sb();
    model(q);
    send_q(q);
    drain();
    compare(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, m_if.tvalid, 0);
    check({tag, "_tdata"}, m_if.tdata, 0);
    check({tag, "_tlast"}, m_if.tlast, 0);
    check({tag, "_tuser"}, m_if.tuser, 0);
    check({tag, "_ok"}, frame_ok, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_sready"}, s_if.tready, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    int len, s;
    logic [7:0] b;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    clear_sb();

    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_sready", s_if.tready, 1);

    run("good3", '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
    run("bad3", '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98});
    run("junk_len1", '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h81});
    run("len0", '{8'hA5, 8'h00, 8'h00});
    run("a5_data", '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hB6});

    // checksum byte chosen so the frame sums to zero
    q = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    clear_sb();
    model(q);
    fork
      send_q(q);
      begin
        for (int i = 0; i < 200 && got_q.size() < 1; i++)
          @(negedge clk);
        saw_s_stall = 1'b0;
        low_cnt = 20;
      end
    join
    drain();
    check("stall_sready_drop", saw_s_stall, 1);
    compare("stall");

    clear_sb();
    low_cnt = 30;
    send_q('{8'hA5, 8'h03, 8'h11, 8'h22});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    check("mid_reset_beats", got_q.size(), 0);
    check("mid_reset_pulses", n_ok + n_bad, 0);
    low_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset_sready", s_if.tready, 1);
    run("after_reset", '{8'hA5, 8'h01, 8'h55, 8'hAA});

`ifdef UART_PARSER_TIMEOUT_EN
    begin
      int c;
      clear_sb();
      send_q('{8'hA5, 8'h02, 8'h10});
      c = 0;
      while (c < 450 && n_bad == 0) begin
        @(negedge clk);
        c++;
      end
      check("tmo_not_early", c >= 390, 1);
      check("tmo_not_late", c < 430, 1);
      drain();
      exp_q.push_back({1'b1, 1'b1, 8'h10});
      e_bad = 1;
      compare("timeout");
      run("tmo_restart", '{8'hA5, 8'h01, 8'h55, 8'hAA});
    end
`endif

    rnd_rdy = 1'b1;
    gap_max = 2;
    q.delete();
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        q.push_back(b);
      end
      if (f == 0) len = 255;
      else if ($urandom_range(0, 5) == 0) len = 0;
      else len = $urandom_range(1, 12);
      q.push_back(8'hA5);
      q.push_back(8'(len));
      s = len;
      for (int k = 0; k < len; k++) begin
        b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
        q.push_back(b);
        s += int'(b);
      end
      b = 8'((256 - (s % 256)) % 256);
      if ($urandom_range(0, 2) == 0) b = b + 8'($urandom_range(1, 255));
      q.push_back(b);
    end
    run("random", q);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
